// File: rtl/base_credit_pkg.sv
// Shared sizing helpers for the credit-based link transmitter.
// Used by base_credit_cnt and base_credit_tx.
package base_credit_pkg;

   localparam int unsigned CR_WIDTH_MAX = 16;
   localparam int unsigned CREDITS_MAX  = 1024;

   // Bits needed to hold a count in the range 0..n inclusive.
   function automatic int unsigned cr_bits(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   typedef logic [$clog2(CREDITS_MAX + 1)-1:0] cr_cnt_t;

endpackage

// File: rtl/base_credit_cnt.sv
// Saturating up/down credit counter: one decrement per sent beat, up to 2^cr_width-1 returns per cycle.
// BASE_CREDIT_TX_CHECK_EN enables overflow detection and saturation; otherwise the count wraps.
module base_credit_cnt
   import base_credit_pkg::*;
#(
   parameter int unsigned CREDITS  = 8,
   parameter int unsigned cr_width = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         dec,
   input  logic [cr_width-1:0]          inc,
   output logic [cr_bits(CREDITS)-1:0]  cnt,
   output logic                         nz,
   output logic                         full,
   output logic                         ovf
);

   localparam int unsigned LOG_CR = cr_bits(CREDITS);

   logic [LOG_CR-1:0] cnt_q, cnt_d;

`ifdef BASE_CREDIT_TX_CHECK_EN
   localparam int unsigned SW = LOG_CR + cr_width + 1;

   // Wide enough that neither the decrement nor the largest return can wrap.
   logic [SW-1:0] sum;

   always_comb begin
      sum   = SW'(cnt_q) - SW'(dec) + SW'(inc);
      ovf   = (sum > SW'(CREDITS));
      cnt_d = ovf ? LOG_CR'(CREDITS) : sum[LOG_CR-1:0];
   end

   overflow_chk: assert property (@(posedge clk) disable iff (!reset) !ovf)
      else $error("base_credit_cnt: credit return overflows pool of %0d", CREDITS);
`else
   always_comb begin
      ovf   = 1'b0;
      cnt_d = cnt_q - LOG_CR'(dec) + LOG_CR'(inc);
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= LOG_CR'(CREDITS);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign nz   = (cnt_q != '0);
   assign full = (cnt_q == LOG_CR'(CREDITS));

endmodule

// File: rtl/base_credit_tx.sv
// Credit-based link transmitter feeding a receiver FIFO that has no backpressure.
// Optional overflow checking is controlled by BASE_CREDIT_TX_CHECK_EN (see base_credit_cnt).
module base_credit_tx
   import base_credit_pkg::*;
#(
   parameter int unsigned width    = 1,
   parameter int unsigned CREDITS  = 8,
   parameter int unsigned cr_width = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_v,
   input  logic [width-1:0]    i_d,
   output logic                i_r,
   output logic                o_v,
   output logic [width-1:0]    o_d,
   input  logic [cr_width-1:0] cr_n,
   output logic                o_idle,
   output logic                o_err
);

   localparam int unsigned LOG_CR = cr_bits(CREDITS);

   logic              send;
   logic              cr_nz;
   logic              cr_full;
   logic              cr_ovf;
   logic [LOG_CR-1:0] cnt_unused;

   logic             o_v_q, o_v_d;
   logic [width-1:0] o_d_q, o_d_d;
   logic             err_q, err_d;

   base_credit_cnt #(
      .CREDITS  (CREDITS),
      .cr_width (cr_width)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .dec   (send),
      .inc   (cr_n),
      .cnt   (cnt_unused),
      .nz    (cr_nz),
      .full  (cr_full),
      .ovf   (cr_ovf)
   );

   // Ready comes straight from the registered count, so returns never bypass into i_r.
   assign i_r  = cr_nz;
   assign send = i_v & i_r;

   always_comb begin
      o_v_d = send;
      o_d_d = o_d_q;
      err_d = err_q | cr_ovf;
      if (send) begin
         o_d_d = i_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         o_v_q <= 1'b0;
         o_d_q <= '0;
         err_q <= 1'b0;
      end else begin
         o_v_q <= o_v_d;
         o_d_q <= o_d_d;
         err_q <= err_d;
      end
   end

   assign o_v    = o_v_q;
   assign o_d    = o_d_q;
   assign o_err  = err_q;
   assign o_idle = cr_full & ~o_v_q;

endmodule

// File: tb/tb_base_credit_tx.sv
// Directed self-checking bench for base_credit_tx with CREDITS=4, cr_width=2, width=8.
module tb_base_credit_tx;

   logic       clk;
   logic       reset;
   logic       i_v;
   logic [7:0] i_d;
   logic       i_r;
   logic       o_v;
   logic [7:0] o_d;
   logic [1:0] cr_n;
   logic       o_idle;
   logic       o_err;

   int unsigned total;
   int unsigned bad;

   base_credit_tx #(
      .width    (8),
      .CREDITS  (4),
      .cr_width (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .i_v    (i_v),
      .i_d    (i_d),
      .i_r    (i_r),
      .o_v    (o_v),
      .o_d    (o_d),
      .cr_n   (cr_n),
      .o_idle (o_idle),
      .o_err  (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      i_v   = 1'b0;
      i_d   = 8'h00;
      cr_n  = 2'd0;

      step();
      step();
      reset = 1'b1;
      step();
      check("rst_i_r",   32'(i_r),    32'd1);
      check("rst_idle",  32'(o_idle), 32'd1);
      check("rst_o_v",   32'(o_v),    32'd0);
      check("rst_o_err", 32'(o_err),  32'd0);
      check("rst_o_d",   32'(o_d),    32'h0);
      check("rst_cnt",   32'(dut.u_cnt.cnt), 32'd4);

      // Stream 0x1..0x4 drains the four credits, one per cycle.
      i_v = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         i_d = 8'(k);
         step();
         check("exh_o_v", 32'(o_v), 32'd1);
         check("exh_o_d", 32'(o_d), 32'(k));
         check("exh_i_r", 32'(i_r), (k == 4) ? 32'd0 : 32'd1);
      end
      check("exh_idle", 32'(o_idle), 32'd0);

      // Beat 0x5 is presented but must stall with no credits.
      i_d = 8'h05;
      for (int k = 0; k < 2; k++) begin
         step();
         check("stall_o_v", 32'(o_v), 32'd0);
         check("stall_o_d", 32'(o_d), 32'h4);
         check("stall_i_r", 32'(i_r), 32'd0);
      end

      cr_n = 2'd1;
      #1;
      check("no_bypass_i_r", 32'(i_r), 32'd0);
      step();
      cr_n = 2'd0;
      check("repl_i_r", 32'(i_r), 32'd1);
      check("repl_o_v", 32'(o_v), 32'd0);
      step();
      check("repl_send_o_v", 32'(o_v), 32'd1);
      check("repl_send_o_d", 32'(o_d), 32'h5);
      check("repl_i_r_low",  32'(i_r), 32'd0);
      i_d = 8'h06;
      step();
      check("repl_after_o_v", 32'(o_v), 32'd0);
      check("repl_after_i_r", 32'(i_r), 32'd0);
      i_v = 1'b0;

      // Bring cnt to 2, then send with a return of 2 in the same cycle.
      cr_n = 2'd2;
      step();
      check("sim_pre_cnt", 32'(dut.u_cnt.cnt), 32'd2);
      i_v  = 1'b1;
      cr_n = 2'd2;
      step();
      check("sim_cnt",   32'(dut.u_cnt.cnt), 32'd3);
      check("sim_o_v",   32'(o_v),   32'd1);
      check("sim_o_d",   32'(o_d),   32'h6);
      check("sim_o_err", 32'(o_err), 32'd0);
      i_v  = 1'b0;
      cr_n = 2'd1;
      step();
      cr_n = 2'd0;
      check("full_cnt",  32'(dut.u_cnt.cnt), 32'd4);
      check("full_idle", 32'(o_idle), 32'd1);

      // Return one credit while already full.
      cr_n = 2'd1;
      step();
      cr_n = 2'd0;
`ifdef BASE_CREDIT_TX_CHECK_EN
      check("ovf_cnt",   32'(dut.u_cnt.cnt), 32'd4);
      check("ovf_o_err", 32'(o_err), 32'd1);
      step();
      check("ovf_sticky", 32'(o_err), 32'd1);
`else
      check("ovf_cnt",   32'(dut.u_cnt.cnt), 32'd5);
      check("ovf_o_err", 32'(o_err), 32'd0);
      step();
      check("ovf_sticky", 32'(o_err), 32'd0);
`endif

      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rst2_cnt",   32'(dut.u_cnt.cnt), 32'd4);
      check("rst2_o_err", 32'(o_err), 32'd0);

      // Send three beats to leave cnt=1 with a beat in flight, then reset.
      i_v = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_d = 8'(8'hA + k);
         step();
      end
      check("mid_cnt", 32'(dut.u_cnt.cnt), 32'd1);
      check("mid_o_v", 32'(o_v), 32'd1);
      check("mid_o_d", 32'(o_d), 32'hC);
      reset = 1'b0;
      step();
      reset = 1'b1;
      i_v   = 1'b0;
      check("mid_rst_o_v",   32'(o_v),    32'd0);
      check("mid_rst_cnt",   32'(dut.u_cnt.cnt), 32'd4);
      check("mid_rst_o_err", 32'(o_err),  32'd0);
      check("mid_rst_idle",  32'(o_idle), 32'd1);
      check("mid_rst_o_d",   32'(o_d),    32'h0);
      check("mid_rst_i_r",   32'(i_r),    32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/base_credit_tx.md
# base_credit_tx

Credit-based link transmitter: the sending end of a link whose receiver is a `base_fifo` of known depth that gives no ready backpressure. It accepts a valid/ready stream and forwards each beat as a registered single-cycle strobe. It holds one credit per free receiver slot and consumes a credit per beat sent. Credits returned by the receiver, counted as the receiver pops entries, replenish the pool.

## Interface
Parameters:
- `width`, 1, data width in bits.
- `CREDITS`, 8, initial and maximum credit count; equals the receiver FIFO DEPTH; range 1 to 1024.
- `cr_width`, 1, width of the credit-return count per cycle.

Ports:
- `clk` in 1: sole clock; all state on rising edge.
- `reset` in 1: synchronous, active-low (asserted when 0).
- `i_v` in 1: input beat valid.
- `i_d` in `width`: input beat data.
- `i_r` in 1: input ready; high when at least one credit is held.
- `o_v` in-link out 1: registered beat strobe to the receiver FIFO `i_v`.
- `o_d` out `width`: registered beat data; meaningful only when `o_v`=1.
- `cr_n` in `cr_width`: number of credits returned this cycle, from 0 to 2^cr_width−1.
- `o_idle` out 1: high when credits==CREDITS and `o_v`=0.
- `o_err` out 1: sticky credit-overflow flag.

## Operation
- State:
  - credit counter `cnt`, `LOG_CR`=$clog2(CREDITS+1) bits.
  - output register `o_v`/`o_d`.
  - sticky `o_err`.
- Accept: `send = i_v & i_r`. `i_r = (cnt != 0)`, decoded from the `cnt` register only and never from `i_v` or `cr_n`.
- Next-state count: `cnt_nxt = cnt − send + cr_n`.
  - Computed in `LOG_CR+cr_width+1` bits.
  - If the result exceeds CREDITS: `cnt` saturates to CREDITS and `o_err` sets.
  - Underflow is impossible by construction, because `send` requires `cnt`≥1.
- Simultaneous send and return: the two are applied in the same cycle (net `cr_n`−1). No ordering dependency exists between them.
- A return arriving at `cnt`=0 makes `i_r` rise the next cycle. There is no same-cycle bypass.
- Output register:
  - `o_v` ← `send` every cycle; the output is never held.
  - `o_d` ← `i_d` when `send`; otherwise it holds its previous value.
- `o_err` clears only on reset.
- Reset values:
  - `cnt`=CREDITS, `o_v`=0, `o_d`=0, `o_err`=0.
  - Hence `i_r`=1 and `o_idle`=1 after reset.
- Reset mid-operation: in-flight beats are discarded and credits reload to CREDITS. The receiver must be reset in the same cycle.

## Timing
- Latency: beat accepted at edge t appears with `o_v`=1 during cycle t+1.
- Throughput: one beat per cycle while `cnt`≥1. A sustained stream drains `cnt` by 1 per cycle without returns.
- Credit return during cycle t raises `cnt` at t+1. The minimum round trip from credits=0 to the next accept is 1 cycle after the return.
- `i_r` transitions only at clock edges.
- `o_idle` reflects registered state and updates one cycle after the last send or return.

## Configuration
- `BASE_CREDIT_TX_CHECK_EN`
  - Defined: overflow detection is active. `o_err` sets on any cycle where `cnt − send + cr_n` > CREDITS, and the counter saturates. A simulation-only `$error` fires on the same cycle.
  - Undefined: no comparator or check. `o_err` is tied 0 and the counter wraps modulo 2^LOG_CR on overflow; this is an illegal use.

## Structure
- Package `base_credit_pkg` holds:
  - function `cr_bits(n)`, returning $clog2(n+1);
  - the `cr_width` upper bound constant;
  - typedef `cr_cnt_t` for the sized count.
- One sub-module, `base_credit_cnt`, holds the saturating up/down counter with parameters `CREDITS` and `cr_width`.
  - Inputs: `dec` (1 bit) and `inc` (`cr_width`).
  - Outputs: `cnt`, `nz`, `full`, `ovf`.
  - `base_credit_tx` instantiates it and adds the output register, idle decode and error latch.

## Test plan
- Reset then idle: CREDITS=4, hold `reset`=0 two cycles, then release. Expect `i_r`=1, `o_idle`=1, `o_v`=0, `o_err`=0.
- Credit exhaustion: CREDITS=4, `i_v`=1 for 6 cycles with data 0x1..0x6 and no returns.
  - Expect `o_v` high for 4 cycles carrying 0x1–0x4, starting one cycle after the first accept.
  - Expect `i_r`=0 from the 5th cycle; beats 0x5 and 0x6 are held at the input.
- Replenish: from `cnt`=0, pulse `cr_n`=1 for one cycle. Expect `i_r`=1 the next cycle; exactly one more beat (0x5) is sent, then `i_r`=0.
- Simultaneous send and return: CREDITS=4, `cr_width`=2, `cnt`=2, `send`=1 with `cr_n`=2 in the same cycle. Expect `cnt`=3 next cycle and no `o_err`.
- Overflow (macro defined): `cnt`=4=CREDITS, no send, `cr_n`=1. Expect `cnt` to stay 4, `o_err`=1 next cycle and remain 1 until reset. With the macro undefined, `o_err` stays 0.
- Reset mid-stream: `cnt`=1 with `o_v`=1, assert `reset`=0 for one cycle. Expect `o_v`=0, `cnt`=4, `o_err`=0 and `o_idle`=1 the following cycle.
